// File: rtl/ace_pkg.sv
// Shared definitions for the ACE snoop initiator: FSM states, CR response bit
// positions and the AC snoop opcodes used by local requesters.
package ace_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AC_ISSUE,
      S_CR_WAIT,
      S_CD_COLLECT,
      S_DONE
   } state_t;

   localparam int CR_DATA_XFER  = 0;
   localparam int CR_ERROR      = 1;
   localparam int CR_PASS_DIRTY = 2;
   localparam int CR_IS_SHARED  = 3;
   localparam int CR_WAS_UNIQUE = 4;

   localparam logic [3:0] SNOOP_READ_SHARED   = 4'b0001;
   localparam logic [3:0] SNOOP_READ_UNIQUE   = 4'b0111;
   localparam logic [3:0] SNOOP_CLEAN_INVALID = 4'b1001;
   localparam logic [3:0] SNOOP_MAKE_INVALID  = 4'b1101;

   // Response reported when the cache never answered: only the Error bit set.
   localparam logic [4:0] TIMEOUT_RESP = 5'b00010;

endpackage

// File: rtl/ace_snoop_timer.sv
// Wait-cycle counter: clear restarts it, enable counts one idle cycle, and
// expired flags the idle cycle that would bring the count up to LIMIT.
module ace_snoop_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] count;

   assign expired = enable && (count == W'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst || clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + W'(1);
   end

endmodule

// File: rtl/ace_snoop_initiator.sv
// Issues one ACE snoop at a time on AC, collects the CR response and any CD
// data beats, then reports the outcome with a single-cycle done pulse.
module ace_snoop_initiator
   import ace_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 255,
   parameter int MAX_BEATS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [3:0]        req_snoop,
   output logic              acvalid,
   input  logic              acready,
   output logic [ADDR_W-1:0] acaddr,
   output logic [3:0]        acsnoop,
   input  logic              crvalid,
   output logic              crready,
   input  logic [4:0]        crresp,
   input  logic              cdvalid,
   output logic              cdready,
   input  logic [DATA_W-1:0] cddata,
   input  logic              cdlast,
   output logic              done,
   output logic [4:0]        done_resp,
   output logic              done_dirty,
   output logic [2:0]        done_beats,
   output logic              timeout_err,
   output logic              rd_data_valid,
   output logic [DATA_W-1:0] rd_data
);

   state_t     state;
   logic [4:0] resp_q;
   logic [2:0] beats;
   logic [2:0] beats_next;
   logic       cd_beat;
   logic       timer_clear;
   logic       timer_en;
   logic       timer_expired;

   assign req_ready     = (state == S_IDLE) && !rst;
   assign cd_beat       = (state == S_CD_COLLECT) && cdvalid && cdready;
   assign rd_data_valid = cd_beat && !rst;
   assign rd_data       = rd_data_valid ? cddata : '0;
   assign beats_next    = (beats == 3'(MAX_BEATS)) ? beats : beats + 3'd1;

   assign done_resp  = resp_q;
   assign done_dirty = resp_q[CR_PASS_DIRTY];
   assign done_beats = beats;

   // Timer restarts whenever a wait state is entered; CD beats pause it but
   // do not restart it, so the budget covers the whole data phase.
   assign timer_en    = ((state == S_CR_WAIT) && !crvalid) ||
                        ((state == S_CD_COLLECT) && !cdvalid);
   assign timer_clear = !((state == S_CR_WAIT) || (state == S_CD_COLLECT)) ||
                        ((state == S_CR_WAIT) && crvalid);

   ace_snoop_timer #(.LIMIT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         acvalid     <= 1'b0;
         acaddr      <= '0;
         acsnoop     <= '0;
         crready     <= 1'b0;
         cdready     <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         resp_q      <= '0;
         beats       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  acaddr      <= req_addr;
                  acsnoop     <= req_snoop;
                  acvalid     <= 1'b1;
                  resp_q      <= '0;
                  beats       <= '0;
                  timeout_err <= 1'b0;
                  state       <= S_AC_ISSUE;
               end
            end
            S_AC_ISSUE: begin
               if (acready) begin
                  acvalid <= 1'b0;
                  crready <= 1'b1;
                  state   <= S_CR_WAIT;
               end
            end
            S_CR_WAIT: begin
               if (crvalid) begin
                  resp_q  <= crresp;
                  crready <= 1'b0;
                  if (crresp[CR_DATA_XFER]) begin
                     cdready <= 1'b1;
                     state   <= S_CD_COLLECT;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end else if (timer_expired) begin
                  resp_q      <= TIMEOUT_RESP;
                  timeout_err <= 1'b1;
                  crready     <= 1'b0;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_CD_COLLECT: begin
               if (cdvalid) begin
                  beats <= beats_next;
                  if (cdlast || (beats_next == 3'(MAX_BEATS))) begin
                     cdready <= 1'b0;
                     done    <= 1'b1;
                     state   <= S_DONE;
                  end
               end else if (timer_expired) begin
                  resp_q      <= TIMEOUT_RESP;
                  timeout_err <= 1'b1;
                  cdready     <= 1'b0;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ace_snoop_initiator.md
ACE_SNOOP_INITIATOR -- requirements
Module: ace_snoop_initiator

Interface
REQ-001 Parameter ADDR_W, default 32, AC address width.
REQ-002 Parameter DATA_W, default 32, CD data width.
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting on CR/CD before abort.
REQ-004 Parameter MAX_BEATS, default 4, CD beats per line.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  local snoop request.
REQ-008 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-009 req_addr  input  ADDR_W  line address to snoop.
REQ-010 req_snoop  input  4  AC snoop opcode.
REQ-011 acvalid  output  1  snoop address valid.
REQ-012 acready  input  1  cache accepts snoop.
REQ-013 acaddr  output  ADDR_W  snoop address.
REQ-014 acsnoop  output  4  snoop opcode.
REQ-015 crvalid  input  1  snoop response valid.
REQ-016 crready  output  1  initiator accepts response.
REQ-017 crresp  input  5  [0]DataTransfer [1]Error [2]PassDirty [3]IsShared [4]WasUnique.
REQ-018 cdvalid, cddata[DATA_W], cdlast  input  snoop data beat; cdready output 1.
REQ-019 done  output  1  one-cycle completion pulse.
REQ-020 done_resp  output  5  captured crresp; done_dirty output 1; done_beats output 3; timeout_err output 1.
REQ-021 rd_data_valid output 1, rd_data output DATA_W: forwarded CD beat, valid on cdvalid&cdready.

Function
REQ-022 FSM states IDLE, AC_ISSUE, CR_WAIT, CD_COLLECT, DONE; one transaction outstanding.
REQ-023 IDLE: req_ready=1; on req_valid register addr/opcode, go AC_ISSUE next cycle.
REQ-024 AC_ISSUE: acvalid=1, acaddr/acsnoop stable until acvalid&acready; then CR_WAIT.
REQ-025 acvalid never deasserts before handshake; same-cycle acready completes in one cycle.
REQ-026 CR_WAIT: crready=1; on crvalid capture crresp; if crresp[0]=1 go CD_COLLECT, else DONE.
REQ-027 CD_COLLECT: cdready=1; count accepted beats (3-bit, saturate at MAX_BEATS); exit to DONE on beat with cdlast=1 or count reaching MAX_BEATS.
REQ-028 cdvalid in any state other than CD_COLLECT is ignored (cdready=0).
REQ-029 DONE: done=1 one cycle; done_dirty=captured PassDirty; done_beats=beat count; return IDLE.
REQ-030 Timeout counter cleared on entering CR_WAIT and CD_COLLECT, increments each non-handshake cycle; on reaching TIMEOUT go DONE with timeout_err=1, done_resp=5'b00010.
REQ-031 AC_ISSUE has no timeout; holds indefinitely.
REQ-032 req_ready=0 outside IDLE; back-to-back requests: earliest next acceptance one cycle after done.
REQ-033 Minimum latency req accept to done: 4 cycles (no data, immediate handshakes).
REQ-034 crresp[1] Error propagated in done_resp; no special action.

Reset
REQ-035 rst synchronous, active-high; overrides all inputs including mid-transaction handshakes.
REQ-036 Reset values: state IDLE, acvalid/crready/cdready/done/timeout_err/rd_data_valid=0, req_ready=0 during reset cycle, all captured registers and counters 0.
REQ-037 Reset mid-transaction abandons it with no done pulse.

Structure
REQ-038 Shared package ace_pkg holds state encoding, crresp bit indices, snoop opcode constants (ReadUnique, CleanInvalid, MakeInvalid, ReadShared).
REQ-039 One sub-module natural: ace_snoop_timer (loadable counter, clear/enable/expired), instantiated once.

Verification
REQ-040 req addr 0x1000 opcode ReadShared, acready same cycle, crresp=5'b01000 no data -> acaddr=0x1000, done after 4 cycles, done_beats=0, done_dirty=0.
REQ-041 crresp=5'b00101, 4 cdvalid beats 0xA..0xD, cdlast on 4th -> rd_data sequence A,B,C,D, done_beats=4, done_dirty=1.
REQ-042 acready held low 10 cycles -> acvalid/acaddr stable for all 10, no timeout.
REQ-043 crvalid never asserted, TIMEOUT=8 -> done with timeout_err=1 after 8 CR_WAIT cycles.
REQ-044 rst asserted during CD_COLLECT beat 2 -> next cycle IDLE, all outputs 0, no done.
REQ-045 req_valid held high across completion -> second request accepted exactly one cycle after done, stray cdvalid in IDLE ignored.
